// File: rtl/reg_ctrl_pkg.sv
// Shared types for the register-file command controller: FSM states, operation kind
// and the default frame opcodes.
package reg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    READ_WAIT,
    SEND
  } state_t;

  typedef enum logic {
    WR,
    RD
  } op_t;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

endpackage

// File: rtl/reg_rsp_serializer.sv
// Parallel-load response serializer: takes one register word and emits it LSB byte
// first on a valid/ready stream, pulsing done on the last handshake.
module reg_rsp_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [REG_WIDTH-1:0]  load_data,
  output logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Tx_Valid,
  input  logic                  Tx_Ready,
  output logic                  done
);

  localparam int NBYTES = REG_WIDTH / DATA_WIDTH;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  logic [REG_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 valid_reg;
  logic                 handshake;

  assign handshake = valid_reg && Tx_Ready;
  assign done      = handshake && (cnt_reg == LAST_BYTE);
  assign Tx_Data   = shift_reg[DATA_WIDTH-1:0];
  assign Tx_Valid  = valid_reg;

  // Shifting only on a handshake keeps Tx_Data stable under backpressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (handshake) begin
      shift_reg <= shift_reg >> DATA_WIDTH;
      cnt_reg   <= cnt_reg + 1'b1;
      if (cnt_reg == LAST_BYTE) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Command-frame initiator: decodes write/read frames from the receive byte stream,
// issues one register-file access per frame and streams read results back out.
module reg_file_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    REG_WIDTH  = 16,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = reg_ctrl_pkg::WR_CMD,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = reg_ctrl_pkg::RD_CMD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Rx_Data,
  input  logic                  Rx_Valid,
  output logic                  Rx_Ready,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [REG_WIDTH-1:0]  RF_WrData,
  input  logic [REG_WIDTH-1:0]  RF_RdData,
  output logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Tx_Valid,
  input  logic                  Tx_Ready,
  output logic                  Cmd_Err,
  output logic                  Busy
);

  import reg_ctrl_pkg::*;

  localparam int NBYTES = REG_WIDTH / DATA_WIDTH;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  state_t                state_reg, state_next;
  op_t                   op_reg;
  logic [CNT_W-1:0]      byte_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [REG_WIDTH-1:0]  wr_data_reg;
  logic                  cmd_err_reg;
  logic                  rx_accept;
  logic                  is_wr_cmd;
  logic                  is_rd_cmd;
  logic                  rsp_load;
  logic                  tx_done;

  // Ready is gated by RST so no byte is ever consumed while the block is held in reset.
  assign Rx_Ready  = !RST && ((state_reg == IDLE) || (state_reg == GET_ADDR) ||
                              (state_reg == GET_DATA));
  assign rx_accept = Rx_Valid && Rx_Ready;
  assign is_wr_cmd = (Rx_Data == WR_CMD);
  assign is_rd_cmd = (Rx_Data == RD_CMD);

  assign RF_WrEn    = (state_reg == WRITE);
  assign RF_RdEn    = (state_reg == READ);
  assign RF_Address = addr_reg;
  assign RF_WrData  = wr_data_reg;
  assign Cmd_Err    = cmd_err_reg;
  assign Busy       = (state_reg != IDLE);
  assign rsp_load   = (state_reg == READ_WAIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rx_accept && (is_wr_cmd || is_rd_cmd)) begin
          state_next = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (rx_accept) begin
          state_next = (op_reg == WR) ? GET_DATA : READ;
        end
      end
      GET_DATA: begin
        if (rx_accept && (byte_cnt_reg == LAST_BYTE)) begin
          state_next = WRITE;
        end
      end
      WRITE:     state_next = IDLE;
      READ:      state_next = READ_WAIT;
      READ_WAIT: state_next = SEND;
      SEND: begin
        if (tx_done) begin
          state_next = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // Frame datapath; address and write data persist between frames.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_reg       <= WR;
      byte_cnt_reg <= '0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      cmd_err_reg  <= 1'b0;
    end else begin
      cmd_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          byte_cnt_reg <= '0;
          if (rx_accept) begin
            if (is_wr_cmd) begin
              op_reg <= WR;
            end else if (is_rd_cmd) begin
              op_reg <= RD;
            end else begin
              cmd_err_reg <= 1'b1;
            end
          end
        end
        GET_ADDR: begin
          byte_cnt_reg <= '0;
          if (rx_accept) begin
            addr_reg <= Rx_Data[ADDR_WIDTH-1:0];
          end
        end
        GET_DATA: begin
          if (rx_accept) begin
            wr_data_reg[byte_cnt_reg*DATA_WIDTH +: DATA_WIDTH] <= Rx_Data;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
        end
        default: begin
          byte_cnt_reg <= '0;
        end
      endcase
    end
  end

  reg_rsp_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
  ) u_rsp_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (rsp_load),
    .load_data (RF_RdData),
    .Tx_Data   (Tx_Data),
    .Tx_Valid  (Tx_Valid),
    .Tx_Ready  (Tx_Ready),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a small register-file model and a Tx byte monitor.
module tb_reg_file_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Rx_Ready;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [2:0]  RF_Address;
  logic [15:0] RF_WrData;
  logic [15:0] RF_RdData;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_Ready;
  logic        Cmd_Err;
  logic        Busy;

  int check_cnt = 0;
  int pass_cnt  = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          err_cnt = 0;
  logic [2:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [2:0]  last_rd_addr = '0;
  logic [7:0]  tx_q[$];
  logic [15:0] mem [8];

  always #5 CLK = ~CLK;

  reg_file_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .Rx_Data    (Rx_Data),
    .Rx_Valid   (Rx_Valid),
    .Rx_Ready   (Rx_Ready),
    .RF_WrEn    (RF_WrEn),
    .RF_RdEn    (RF_RdEn),
    .RF_Address (RF_Address),
    .RF_WrData  (RF_WrData),
    .RF_RdData  (RF_RdData),
    .Tx_Data    (Tx_Data),
    .Tx_Valid   (Tx_Valid),
    .Tx_Ready   (Tx_Ready),
    .Cmd_Err    (Cmd_Err),
    .Busy       (Busy)
  );

  // Register file model: synchronous write, registered read.
  always @(posedge CLK) begin
    if (RF_WrEn) mem[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= mem[RF_Address];
  end

  // Inputs change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RF_WrEn) begin
        wr_cnt++;
        last_wr_addr = RF_Address;
        last_wr_data = RF_WrData;
      end
      if (RF_RdEn) begin
        rd_cnt++;
        last_rd_addr = RF_Address;
      end
      if (RF_WrEn && RF_RdEn) both_cnt++;
      if (Cmd_Err) err_cnt++;
      if (Tx_Valid && Tx_Ready) begin
        tx_q.push_back(Tx_Data);
        $display("tx byte %02h", Tx_Data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    while (!Rx_Ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(Rx_Ready), 32'd1);
    tick();
    Rx_Valid = 1'b0;
    $display("rx byte %02h", b);
    repeat (gap) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem[3]    = 16'hBEEF;
    RF_RdData = 16'h0000;
    RST       = 1'b1;
    Rx_Data   = 8'h00;
    Rx_Valid  = 1'b0;
    Tx_Ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rx_ready", 32'(Rx_Ready), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_wren", 32'(RF_WrEn), 0);
    check("rst_rden", 32'(RF_RdEn), 0);
    check("rst_tx_valid", 32'(Tx_Valid), 0);
    check("rst_addr", 32'(RF_Address), 0);
    check("rst_wrdata", 32'(RF_WrData), 0);
    check("rst_tx_data", 32'(Tx_Data), 0);
    RST = 1'b0;
    tick();
    check("idle_rx_ready", 32'(Rx_Ready), 1);

    // Write 1234 to reg 5 with exact strobe latency
    Tx_Ready = 1'b1;
    tx_q.delete();
    send_byte(8'hAA, 0);
    check("wr_busy", 32'(Busy), 1);
    send_byte(8'h05, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    check("wr_strobe_n1", 32'(RF_WrEn), 1);
    check("wr_rx_ready_n1", 32'(Rx_Ready), 0);
    check("wr_addr", 32'(RF_Address), 32'h5);
    check("wr_data", 32'(RF_WrData), 32'h1234);
    tick();
    check("wr_strobe_n2", 32'(RF_WrEn), 0);
    check("wr_rx_ready_n2", 32'(Rx_Ready), 1);
    check("wr_busy_done", 32'(Busy), 0);
    check("wr_count", wr_cnt, 1);
    check("wr_no_tx", tx_q.size(), 0);

    // Read reg 5 back with exact latency
    tx_q.delete();
    send_byte(8'hBB, 0);
    send_byte(8'h05, 0);
    check("rd_strobe_n1", 32'(RF_RdEn), 1);
    check("rd_addr", 32'(RF_Address), 32'h5);
    tick();
    check("rd_strobe_n2", 32'(RF_RdEn), 0);
    check("rd_txv_n2", 32'(Tx_Valid), 0);
    tick();
    check("rd_txv_n3", 32'(Tx_Valid), 1);
    check("rd_txd_n3", 32'(Tx_Data), 32'h34);
    tick();
    check("rd_txd_n4", 32'(Tx_Data), 32'h12);
    check("rd_busy_n4", 32'(Busy), 1);
    tick();
    check("rd_txv_n5", 32'(Tx_Valid), 0);
    check("rd_busy_n5", 32'(Busy), 0);
    check("rd_tx_count", tx_q.size(), 2);
    check("rd_tx0", 32'(tx_q[0]), 32'h34);
    check("rd_tx1", 32'(tx_q[1]), 32'h12);
    check("rd_count", rd_cnt, 1);

    // Backpressure on the response
    tx_q.delete();
    Tx_Ready = 1'b0;
    send_byte(8'hBB, 0);
    send_byte(8'h05, 0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_txv", 32'(Tx_Valid), 1);
      check("bp_txd", 32'(Tx_Data), 32'h34);
      tick();
    end
    Tx_Ready = 1'b1;
    wait_idle();
    check("bp_tx_count", tx_q.size(), 2);
    check("bp_tx0", 32'(tx_q[0]), 32'h34);
    check("bp_tx1", 32'(tx_q[1]), 32'h12);

    // Unknown opcode followed by a normal write
    send_byte(8'h3C, 0);
    check("bad_cmd_err", 32'(Cmd_Err), 1);
    check("bad_busy", 32'(Busy), 0);
    send_byte(8'hAA, 0);
    send_byte(8'h02, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hAB, 0);
    wait_idle();
    check("bad_err_count", err_cnt, 1);
    check("bad_wr_count", wr_cnt, 2);
    check("bad_wr_addr", 32'(last_wr_addr), 32'h2);
    check("bad_wr_data", 32'(last_wr_data), 32'hABCD);

    // Address truncation with Rx_Valid gaps
    send_byte(8'hAA, 3);
    send_byte(8'hFD, 3);
    send_byte(8'h01, 3);
    send_byte(8'h00, 0);
    wait_idle();
    check("gap_wr_count", wr_cnt, 3);
    check("gap_wr_addr", 32'(last_wr_addr), 32'h5);
    check("gap_wr_data", 32'(last_wr_data), 32'h0001);

    // Reset in the middle of a write frame
    wr_before = wr_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_rx_ready", 32'(Rx_Ready), 0);
    check("mid_rst_wrdata", 32'(RF_WrData), 0);
    repeat (2) tick();
    RST = 1'b0;
    tick();
    tx_q.delete();
    send_byte(8'hBB, 0);
    send_byte(8'h03, 0);
    wait_idle();
    check("mid_rst_no_write", wr_cnt, wr_before);
    check("mid_rst_rd_addr", 32'(last_rd_addr), 32'h3);
    check("mid_rst_tx0", 32'(tx_q[0]), 32'hEF);
    check("mid_rst_tx1", 32'(tx_q[1]), 32'hBE);
    check("strobes_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
